// File: rtl/rv_lite_pkg.sv
// Shared encodings for the RISC-V-lite pipeline: load/store size codes,
// byte-enable patterns and the LSU access state.
package rv_lite_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the MEM stage: store-side enables/data/alignment
// check from the EX operands, load-side lane extraction and extension.
module lsu_align
  import rv_lite_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   st_off,
  input  logic [2:0]   st_f3,
  input  logic         st_load,
  input  logic [N-1:0] st_data,
  output logic [3:0]   be,
  output logic [N-1:0] wdata,
  output logic         misalign,
  input  logic [1:0]   ld_off,
  input  logic [2:0]   ld_f3,
  input  logic [N-1:0] rdata,
  output logic [N-1:0] ld_data
);

  function automatic logic [N-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{(N-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [N-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{(N-16){sgn & h[15]}}, h};
  endfunction

  logic [3:0]   be_base;
  logic [N-1:0] masked;

  always_comb begin
    be_base  = BE_WORD;
    masked   = st_data;
    misalign = 1'b0;
    case (st_f3)
      F3_SB, F3_LBU: begin
        be_base = BE_BYTE;
        masked  = {{(N-8){1'b0}}, st_data[7:0]};
      end
      F3_SH, F3_LHU: begin
        be_base  = BE_HALF;
        masked   = {{(N-16){1'b0}}, st_data[15:0]};
        misalign = st_off[0];
      end
      default: begin
        misalign = |st_off;
      end
    endcase
    // Loads always fetch the whole word; the lane is picked on return.
    be    = st_load ? BE_WORD : (be_base << st_off);
    wdata = st_load ? '0 : (masked << {st_off, 3'b000});
  end

  always_comb begin
    case (ld_f3)
      F3_LB:   ld_data = ext8(rdata[{ld_off, 3'b000} +: 8], 1'b1);
      F3_LBU:  ld_data = ext8(rdata[{ld_off, 3'b000} +: 8], 1'b0);
      F3_LH:   ld_data = ext16(rdata[{ld_off[1], 4'b0000} +: 16], 1'b1);
      F3_LHU:  ld_data = ext16(rdata[{ld_off[1], 4'b0000} +: 16], 1'b0);
      F3_LW:   ld_data = rdata;
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage: issues request/grant data-memory accesses for loads/stores,
// passes ALU results through, and registers results for write-back.
module lsu_mem_stage
  import rv_lite_pkg::*;
#(
  parameter int N    = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [N-1:0]    ex_result,
  input  logic [N-1:0]    ex_store_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [RD_W-1:0] ex_rd,
  output logic            stall,
  output logic            dm_req,
  output logic            dm_we,
  output logic [N-1:0]    dm_addr,
  output logic [N-1:0]    dm_wdata,
  output logic [3:0]      dm_be,
  input  logic            dm_gnt,
  input  logic            dm_rvalid,
  input  logic [N-1:0]    dm_rdata,
  output logic            wb_valid,
  output logic [N-1:0]    wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            misalign
);

  lsu_state_t state, state_nxt;

  logic            is_mem, pass, start, done, drop;
  logic [3:0]      be_c;
  logic [N-1:0]    wdata_c, ld_data_c;
  logic            mis_c;
  logic [1:0]      off_p1;
  logic [2:0]      f3_p1;
  logic [RD_W-1:0] rd_p1;
  logic            ld_p1;

  assign is_mem = ex_mem_read | ex_mem_write;

  lsu_align #(.N(N)) u_align (
    .st_off   (ex_result[1:0]),
    .st_f3    (ex_funct3),
    .st_load  (ex_mem_read),
    .st_data  (ex_store_data),
    .be       (be_c),
    .wdata    (wdata_c),
    .misalign (mis_c),
    .ld_off   (off_p1),
    .ld_f3    (f3_p1),
    .rdata    (dm_rdata),
    .ld_data  (ld_data_c)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    pass      = 1'b0;
    start     = 1'b0;
    done      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid && !is_mem) begin
          pass = 1'b1;
        end else if (ex_valid && mis_c) begin
          drop = 1'b1;
        end else if (ex_valid) begin
          start     = 1'b1;
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dm_gnt) begin
          // Zero-wait memory may return in the grant cycle.
          if (dm_rvalid) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dm_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // p1: access context captured at issue, consumed when the response returns
  always_ff @(posedge clk) begin
    if (start) begin
      off_p1 <= ex_result[1:0];
      f3_p1  <= ex_funct3;
      rd_p1  <= ex_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_be    <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      misalign <= 1'b0;
      ld_p1    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= drop;
      if (pass) begin
        wb_valid <= 1'b1;
        wb_data  <= ex_result;
        wb_rd    <= ex_rd;
      end
      if (start) begin
        dm_req   <= 1'b1;
        dm_we    <= ex_mem_write & ~ex_mem_read;
        dm_addr  <= {ex_result[N-1:2], 2'b00};
        dm_be    <= be_c;
        dm_wdata <= wdata_c;
        ld_p1    <= ex_mem_read;
      end else if (state == REQ && dm_gnt) begin
        dm_req <= 1'b0;
      end
      if (done && ld_p1) begin
        wb_valid <= 1'b1;
        wb_data  <= ld_data_c;
        wb_rd    <= rd_p1;
      end
    end
  end

endmodule
